// File: rtl/game_pkg.sv
// Shared encodings for the FlappyBird command scheduler: run states,
// command codes and the default UART command bytes.
package game_pkg;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_RUN    = 2'd1,
    RS_PAUSED = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    CC_JUMP    = 2'd0,
    CC_START   = 2'd1,
    CC_PAUSE   = 2'd2,
    CC_RESTART = 2'd3
  } cmd_code_e;

  localparam logic [7:0] DEF_CMD_JUMP    = 8'h30;
  localparam logic [7:0] DEF_CMD_START   = 8'h73;
  localparam logic [7:0] DEF_CMD_PAUSE   = 8'h70;
  localparam logic [7:0] DEF_CMD_RESTART = 8'h72;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press (falling edge of key_n).
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_req
);

  logic        k_s1, k_s2, k_prev;
  logic        level;
  logic [19:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_s1    <= 1'b1;
      k_s2    <= 1'b1;
      k_prev  <= 1'b1;
      level   <= 1'b1;
      cnt     <= 20'd0;
      key_req <= 1'b0;
    end else begin
      k_s1    <= key_n;
      k_s2    <= k_s1;
      k_prev  <= k_s2;
      key_req <= 1'b0;
      if (k_s2 != k_prev) begin
        cnt <= 20'd0;
      end else if (cnt != DEB_CYCLES) begin
        cnt <= cnt + 20'd1;
      end
      // k_s2 == k_prev guards against accepting on the very cycle a change arrives
      if (k_s2 == k_prev && cnt == DEB_CYCLES && k_s2 != level) begin
        level   <= k_s2;
        key_req <= ~k_s2;
      end
    end
  end

endmodule

// File: rtl/game_cmd_sched.sv
// Command scheduler: merges UART and key commands into a small queue, owns the
// run/pause state and dispatches one command per frame on the vsync falling edge.
module game_cmd_sched
  import game_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [19:0] DEB_CYCLES  = 20'd500000,
  parameter logic [7:0]  CMD_JUMP    = DEF_CMD_JUMP,
  parameter logic [7:0]  CMD_START   = DEF_CMD_START,
  parameter logic [7:0]  CMD_PAUSE   = DEF_CMD_PAUSE,
  parameter logic [7:0]  CMD_RESTART = DEF_CMD_RESTART
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vs_in,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       key_n,
  output logic [1:0] run_state,
  output logic       frame_tick,
  output logic       jump,
  output logic       start,
  output logic       restart,
  output logic [7:0] drop_cnt
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [1:0] S_IDLE   = RS_IDLE;
  localparam logic [1:0] S_RUN    = RS_RUN;
  localparam logic [1:0] S_PAUSED = RS_PAUSED;
  localparam logic [1:0] C_JUMP   = CC_JUMP;
  localparam logic [1:0] C_START  = CC_START;
  localparam logic [1:0] C_PAUSE  = CC_PAUSE;

  logic [1:0]  state, state_n;
  logic        vs_s1, vs_s2, vs_s3, frame_edge;
  logic        rx_valid_q, rx_rise;
  logic        uart_push, restart_cmd;
  logic [1:0]  uart_code;
  logic        key_req;
  logic [1:0]  key_code;
  logic        pend, pend_n;
  logic [1:0]  pend_code, pend_code_n;
  logic        push_req;
  logic [1:0]  push_code;
  logic [1:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, do_push, drop;
  logic [1:0]  head;
  logic        tick_n, jump_n, start_n;

  assign run_state  = state;
  assign frame_edge = vs_s3 & ~vs_s2;
  assign rx_rise    = rx_data_valid & ~rx_valid_q;
  assign key_code   = (state == S_IDLE) ? C_START : C_JUMP;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .key_req (key_req)
  );

  always_comb begin
    uart_push   = 1'b0;
    uart_code   = C_JUMP;
    restart_cmd = 1'b0;
    if (rx_rise) begin
      if (rx_data == CMD_JUMP) begin
        uart_push = 1'b1;
        uart_code = C_JUMP;
      end else if (rx_data == CMD_START) begin
        uart_push = 1'b1;
        uart_code = C_START;
      end else if (rx_data == CMD_PAUSE) begin
        uart_push = 1'b1;
        uart_code = C_PAUSE;
      end else if (rx_data == CMD_RESTART) begin
        restart_cmd = 1'b1;
      end
    end
  end

  // UART wins; a displaced key request waits in pend, later ones merge into it
  always_comb begin
    push_req    = 1'b0;
    push_code   = uart_code;
    pend_n      = pend;
    pend_code_n = pend_code;
    if (uart_push) begin
      push_req = 1'b1;
      if (key_req && !pend) begin
        pend_n      = 1'b1;
        pend_code_n = key_code;
      end
    end else if (pend) begin
      push_req  = 1'b1;
      push_code = pend_code;
      pend_n    = 1'b0;
    end else if (key_req) begin
      push_req  = 1'b1;
      push_code = key_code;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign pop     = frame_edge && !empty;
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    state_n = state;
    tick_n  = 1'b0;
    jump_n  = 1'b0;
    start_n = 1'b0;
    if (frame_edge) begin
      case (state)
        S_IDLE: begin
          if (!empty && head == C_START) begin
            start_n = 1'b1;
            state_n = S_RUN;
          end
        end
        S_RUN: begin
          tick_n = 1'b1;
          if (!empty && head == C_JUMP)  jump_n  = 1'b1;
          if (!empty && head == C_PAUSE) state_n = S_PAUSED;
        end
        S_PAUSED: begin
          if (!empty && head == C_PAUSE) state_n = S_RUN;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_s3      <= 1'b1;
      rx_valid_q <= 1'b0;
      state      <= S_IDLE;
      frame_tick <= 1'b0;
      jump       <= 1'b0;
      start      <= 1'b0;
      restart    <= 1'b0;
      drop_cnt   <= 8'd0;
      pend       <= 1'b0;
      pend_code  <= C_JUMP;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      vs_s1      <= vs_in;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      rx_valid_q <= rx_data_valid;
      frame_tick <= 1'b0;
      jump       <= 1'b0;
      start      <= 1'b0;
      restart    <= 1'b0;
      if (restart_cmd) begin
        // Restart overrides any dispatch or push landing in the same cycle
        restart <= 1'b1;
        state   <= S_IDLE;
        pend    <= 1'b0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        state      <= state_n;
        frame_tick <= tick_n;
        jump       <= jump_n;
        start      <= start_n;
        pend       <= pend_n;
        pend_code  <= pend_code_n;
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/game_cmd_sched.md
Name: game_cmd_sched

Overview:
- Sits between the UART receiver / key input and the FlappyBird game controller.
- Merges command sources into a small queue and owns the run/pause state.
- Issues the per-frame update tick and dispatches at most one queued command per frame, on the vertical-sync falling edge.
- Downstream logic updates bird and tube positions only on `frame_tick`, and reacts to the `jump` / `start` / `restart` strobes.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of two, 2..16)
- DEB_CYCLES, 20'd500000, key debounce stable-time in clk cycles (10 ms at 50 MHz)
- CMD_JUMP, 8'h30, UART byte for jump ('0')
- CMD_START, 8'h73, UART byte for start ('s')
- CMD_PAUSE, 8'h70, UART byte for pause toggle ('p')
- CMD_RESTART, 8'h72, UART byte for restart ('r')

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low (single clock domain; polarity and synchronicity fixed)
- vs_in  in  1  VGA vertical sync, asynchronous to clk logic
- rx_data  in  8  UART received byte
- rx_data_valid  in  1  level, high while rx_data is valid; rising edge = new byte
- key_n  in  1  push button, active-low, raw/bouncing
- run_state  out  2  0=IDLE, 1=RUN, 2=PAUSED
- frame_tick  out  1  one-cycle strobe per frame while RUN
- jump  out  1  one-cycle strobe, coincident with frame_tick
- start  out  1  one-cycle strobe on IDLE->RUN
- restart  out  1  one-cycle strobe, game controller returns to start state
- drop_cnt  out  8  saturating count of commands dropped on full queue

Behaviour:
- Reset values: run_state=IDLE; all strobes 0; drop_cnt=0; queue empty; debounce counter 0; sync registers 1.
- vs_in is synchronised with 2 flops, then edge-detected. frame_edge = falling edge of the synchronised signal; 3-cycle latency from the pin.
- UART decode:
  - Rising edge of rx_data_valid (registered compare) samples rx_data.
  - Recognised bytes map to codes JUMP=0, START=1, PAUSE=2, RESTART=3.
  - Any other byte is ignored and not counted.
- Key path:
  - key_n is 2-flop synchronised.
  - Debounce counter reloads on any change of the synchronised value; the new level is accepted after DEB_CYCLES consecutive stable cycles.
  - A debounced falling edge generates key_req.
  - key_req maps to START when run_state=IDLE, otherwise to JUMP.
- Arbitration into the queue (push):
  - Fixed priority: UART over key.
  - A key request losing arbitration is held in a one-entry pending flag and pushed on the next cycle without a UART push.
  - A further key_req while the flag is set is merged, not counted.
- Queue full:
  - A push attempted when full is discarded and drop_cnt increments, saturating at 255.
  - A pop and a push in the same cycle when full are both performed; no drop.
- RESTART bypasses the queue:
  - Acts on the decode cycle: restart=1 for one cycle, queue flushed, pending flag cleared, run_state=IDLE.
  - drop_cnt is not cleared.
- Dispatch, on each frame_edge:
  - IDLE:
    - Head START pops, start=1, run_state->RUN.
    - Head JUMP or PAUSE pops and is discarded.
    - No frame_tick.
  - RUN:
    - frame_tick=1.
    - Head JUMP pops, jump=1 in the same cycle.
    - Head PAUSE pops, run_state->PAUSED; frame_tick still asserted this frame.
    - Head START pops, ignored.
  - PAUSED:
    - No frame_tick.
    - Head PAUSE pops, run_state->RUN; ticks resume on the next frame_edge.
    - JUMP or START at head pops, discarded.
  - Empty queue: only frame_tick per state, no pop.
- All strobes are registered outputs, exactly one cycle wide.
- Reset asserted mid-operation clears everything asynchronously. After release, the first frame_edge requires a fresh synchronised falling edge; a stale edge is not produced.

Decomposition:
- game_pkg: run-state enum (IDLE/RUN/PAUSED), command-code enum (JUMP/START/PAUSE/RESTART), default byte constants.
- Sub-module `key_debounce`: synchroniser, stability counter, falling-edge pulse; parameter DEB_CYCLES.
- Queue is inline: circular buffer with one extra pointer bit for full/empty.

Test Plan:
- Reset, then UART 's' then '0' before a frame -> frame 1: start=1, run_state=RUN, no tick. Frame 2: frame_tick=1 and jump=1 in the same cycle.
- RUN, five '0' bytes within one frame (FIFO_DEPTH=4) -> drop_cnt=1. One jump per frame over the next 4 frames, then ticks with no jump.
- RUN, 'p' -> frame_tick on that frame, then none. A second 'p' -> next frame run_state=RUN, ticks resume one frame later.
- UART '0' and a debounced key press in the same cycle -> UART entry queued first, key entry next cycle. Two jumps on consecutive frames.
- key_n bouncing 5 times within DEB_CYCLES/2, then stable low -> exactly one key_req after DEB_CYCLES. Also: key press while IDLE produces start, not jump.
- RUN with 3 queued jumps, send 'r' -> restart pulse next cycle, run_state=IDLE, queue empty, no jump on the following frame. Repeat with rst_n pulsed mid-frame -> all outputs at reset values.
